// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg: shared funct3 codes, FSM states and access helpers for LSU  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int MEM_BYTES = 4 * 64;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACC   = 3'd1,
      S_LD_LO = 3'd2,
      S_LD_HI = 3'd3,
      S_ST_B  = 3'd4,
      S_ERR   = 3'd5,
      S_RESP  = 3'd6
   } lsu_state_t;

   function automatic logic [2:0] size_of(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic is_legal(input logic we, input logic [2:0] funct3);
      if (we)
         return !funct3[2] && (funct3[1:0] != 2'b11);
      else
         return (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_load_align: extracts and extends load data from a two-word window|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_load_align (
   input  logic [31:0] lo_word,
   input  logic [31:0] hi_word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [63:0] w_cat;
   logic [31:0] w_sh;

   assign w_cat = {hi_word, lo_word};
   assign w_sh  = w_cat[{off, 3'b000} +: 32];

   // funct3[2] selects zero extension (lbu/lhu)
   always_comb begin
      case (funct3[1:0])
         2'b00:   data = funct3[2] ? {24'b0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
         2'b01:   data = funct3[2] ? {16'b0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
         default: data = w_sh;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_split_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_split_ctrl: load/store control with misaligned access splitting  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_split_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 64,
   parameter bit SPLIT_EN   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  resp_split,
   output logic                  mem_wr_en,
   output logic [2:0]            mem_funct3,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [ADDR_WIDTH:0] c_mem_bytes = (ADDR_WIDTH+1)'(4 * MEM_SIZE);

   lsu_state_t            r_state;
   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_lo_word;
   logic [1:0]            r_k;

   logic [2:0]            w_size;
   logic [ADDR_WIDTH:0]   w_end;
   logic                  w_oor;
   logic                  w_mis;
   logic                  w_illegal;
   logic                  w_last_k;
   logic [31:0]           w_al_lo;
   logic [31:0]           w_al_hi;
   logic [31:0]           w_ld_data;

   // last byte address computed one bit wider so it cannot wrap
   assign w_size    = size_of(req_funct3);
   assign w_end     = {1'b0, req_addr} + (ADDR_WIDTH+1)'(w_size) - (ADDR_WIDTH+1)'(1);
   assign w_oor     = (w_end >= c_mem_bytes);
   assign w_mis     = ((w_size == 3'd2) && req_addr[0]) ||
                      ((w_size == 3'd4) && (req_addr[1:0] != 2'b00));
   assign w_illegal = !is_legal(req_we, req_funct3);
   assign w_last_k  = (r_k == 2'(size_of(r_funct3) - 3'd1));
   assign req_ready = (r_state == S_IDLE);

   // aligned loads use a zero high word; split loads pair the saved low word
   assign w_al_lo = (r_state == S_LD_HI) ? r_lo_word : mem_rdata;
   assign w_al_hi = (r_state == S_LD_HI) ? mem_rdata : 32'h0;

   lsu_load_align u_align (
      .lo_word (w_al_lo),
      .hi_word (w_al_hi),
      .off     (r_addr[1:0]),
      .funct3  (r_funct3),
      .data    (w_ld_data)
   );

   always_comb begin
      mem_wr_en  = 1'b0;
      mem_funct3 = F3_LW;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (r_state)
         S_ACC: begin
            mem_wr_en  = r_we;
            mem_funct3 = r_funct3;
            mem_addr   = r_addr;
            mem_wdata  = r_wdata;
         end
         S_LD_LO: mem_addr = r_addr & ~ADDR_WIDTH'(3);
         S_LD_HI: mem_addr = (r_addr & ~ADDR_WIDTH'(3)) + ADDR_WIDTH'(4);
         S_ST_B: begin
            mem_wr_en  = 1'b1;
            mem_funct3 = F3_SB;
            mem_addr   = r_addr + ADDR_WIDTH'(r_k);
            mem_wdata  = DATA_WIDTH'(r_wdata[{r_k, 3'b000} +: 8]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_we       <= 1'b0;
         r_funct3   <= 3'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_lo_word  <= '0;
         r_k        <= 2'd0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         resp_split <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_k      <= 2'd0;
                  if (w_illegal || w_oor || (w_mis && !SPLIT_EN))
                     r_state <= S_ERR;
                  else if (!w_mis)
                     r_state <= S_ACC;
                  else if (req_we)
                     r_state <= S_ST_B;
                  else
                     r_state <= S_LD_LO;
               end
            end
            S_ACC: begin
               resp_valid <= 1'b1;
               resp_rdata <= r_we ? '0 : DATA_WIDTH'(w_ld_data);
               r_state    <= S_RESP;
            end
            S_LD_LO: begin
               r_lo_word <= mem_rdata;
               r_state   <= S_LD_HI;
            end
            S_LD_HI: begin
               resp_valid <= 1'b1;
               resp_split <= 1'b1;
               resp_rdata <= DATA_WIDTH'(w_ld_data);
               r_state    <= S_RESP;
            end
            S_ST_B: begin
               if (w_last_k) begin
                  resp_valid <= 1'b1;
                  resp_split <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_k <= r_k + 2'd1;
               end
            end
            S_ERR: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_split <= 1'b0;
               resp_rdata <= '0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
